// File: rtl/execution_alu_issue_pkg.sv
// Shared constants for the ID/EX issue stage: ALU control codes, ALUOp codes, funct values.
package execution_alu_issue_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_REGW  = 5;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_RSVD  = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/execution_alu_issue_if.sv
// Bundle between the ID stage / hazard logic (master) and the ID/EX issue stage (slave).
interface execution_alu_issue_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned REGW  = 5
);
    logic             stall;
    logic             flush;
    logic             valid_in;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [15:0]      imm;
    logic [REGW-1:0]  rs;
    logic [REGW-1:0]  rt;
    logic [REGW-1:0]  rd;
    logic             alu_src;
    logic             reg_dst;
    logic             reg_write_in;
    logic             mem_read_in;
    logic             mem_write_in;
    logic             mem_to_reg_in;
    logic             ex_mem_reg_write;
    logic [REGW-1:0]  ex_mem_rd;
    logic [WIDTH-1:0] ex_mem_result;
    logic             mem_wb_reg_write;
    logic [REGW-1:0]  mem_wb_rd;
    logic [WIDTH-1:0] mem_wb_result;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       control;
    logic [WIDTH-1:0] store_data;
    logic [REGW-1:0]  write_reg;
    logic             valid_out;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             illegal;

    modport master (
        output stall, flush, valid_in, alu_op, funct, rs_data, rt_data, imm, rs, rt, rd,
               alu_src, reg_dst, reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in,
               ex_mem_reg_write, ex_mem_rd, ex_mem_result,
               mem_wb_reg_write, mem_wb_rd, mem_wb_result,
        input  A, B, control, store_data, write_reg, valid_out, reg_write, mem_read,
               mem_write, mem_to_reg, illegal
    );

    modport slave (
        input  stall, flush, valid_in, alu_op, funct, rs_data, rt_data, imm, rs, rt, rd,
               alu_src, reg_dst, reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in,
               ex_mem_reg_write, ex_mem_rd, ex_mem_result,
               mem_wb_reg_write, mem_wb_rd, mem_wb_result,
        output A, B, control, store_data, write_reg, valid_out, reg_write, mem_read,
               mem_write, mem_to_reg, illegal
    );

endinterface

// File: rtl/execution_alu_issue_alu_control_decode.sv
// Combinational ALUOp/funct to 3-bit ALU control decode; unsupported encodings flag illegal.
module alu_control_decode
    import execution_alu_issue_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output alu_ctrl_e  control,
    output logic       illegal
);

    always_comb begin
        control = ALU_ADD;
        illegal = 1'b0;
        case (alu_op_e'(alu_op))
            ALUOP_ADD: control = ALU_ADD;
            ALUOP_SUB: control = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: control = ALU_ADD;
                    FUNCT_SUB: control = ALU_SUB;
                    FUNCT_AND: control = ALU_AND;
                    FUNCT_OR:  control = ALU_OR;
                    FUNCT_SLT: control = ALU_SLT;
                    default:   illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/execution_alu_issue.sv
// ID/EX pipeline register with ALU control generation and EX/MEM, MEM/WB operand forwarding.
module execution_alu_issue
    import execution_alu_issue_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned REGW  = DEF_REGW
) (
    input logic                 clk,
    input logic                 reset,
    execution_alu_issue_if.slave bus
);

    typedef struct packed {
        logic             valid;
        alu_ctrl_e        control;
        logic             illegal;
        logic [REGW-1:0]  rs;
        logic [REGW-1:0]  rt;
        logic [REGW-1:0]  write_reg;
        logic [WIDTH-1:0] rs_data;
        logic [WIDTH-1:0] rt_data;
        logic [15:0]      imm;
        logic             alu_src;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             mem_to_reg;
    } idex_t;

    idex_t      idex_d, idex_q;
    alu_ctrl_e  dec_control;
    logic       dec_illegal;
    logic       idex_en;
    logic [WIDTH-1:0] fwd_rs, fwd_rt;

    alu_control_decode u_decode (
        .alu_op  (bus.alu_op),
        .funct   (bus.funct),
        .control (dec_control),
        .illegal (dec_illegal)
    );

    // Flush overrides stall, so a flushed cycle always writes the bubble.
    assign idex_en = bus.flush || !bus.stall;

    always_comb begin
        idex_d         = '0;
        idex_d.control = ALU_ADD;
        if (!bus.flush && bus.valid_in) begin
            idex_d.valid      = 1'b1;
            idex_d.control    = dec_control;
            idex_d.illegal    = dec_illegal;
            idex_d.rs         = bus.rs;
            idex_d.rt         = bus.rt;
            idex_d.write_reg  = bus.reg_dst ? bus.rd : bus.rt;
            idex_d.rs_data    = bus.rs_data;
            idex_d.rt_data    = bus.rt_data;
            idex_d.imm        = bus.imm;
            idex_d.alu_src    = bus.alu_src;
            idex_d.reg_write  = bus.reg_write_in && !dec_illegal;
            idex_d.mem_read   = bus.mem_read_in;
            idex_d.mem_write  = bus.mem_write_in && !dec_illegal;
            idex_d.mem_to_reg = bus.mem_to_reg_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q         <= '0;
            idex_q.control <= ALU_ADD;
        end else if (idex_en) begin
            idex_q <= idex_d;
        end
    end

    // EX/MEM is the younger result, so it wins over MEM/WB; r0 is never forwarded.
    always_comb begin
        fwd_rs = idex_q.rs_data;
        if (idex_q.valid && bus.ex_mem_reg_write && (bus.ex_mem_rd != '0)
            && (bus.ex_mem_rd == idex_q.rs)) begin
            fwd_rs = bus.ex_mem_result;
        end else if (idex_q.valid && bus.mem_wb_reg_write && (bus.mem_wb_rd != '0)
                     && (bus.mem_wb_rd == idex_q.rs)) begin
            fwd_rs = bus.mem_wb_result;
        end
    end

    always_comb begin
        fwd_rt = idex_q.rt_data;
        if (idex_q.valid && bus.ex_mem_reg_write && (bus.ex_mem_rd != '0)
            && (bus.ex_mem_rd == idex_q.rt)) begin
            fwd_rt = bus.ex_mem_result;
        end else if (idex_q.valid && bus.mem_wb_reg_write && (bus.mem_wb_rd != '0)
                     && (bus.mem_wb_rd == idex_q.rt)) begin
            fwd_rt = bus.mem_wb_result;
        end
    end

    assign bus.A          = fwd_rs;
    assign bus.B          = idex_q.alu_src ? {{(WIDTH-16){idex_q.imm[15]}}, idex_q.imm} : fwd_rt;
    assign bus.store_data = fwd_rt;
    assign bus.control    = idex_q.control;
    assign bus.write_reg  = idex_q.write_reg;
    assign bus.valid_out  = idex_q.valid;
    assign bus.reg_write  = idex_q.reg_write;
    assign bus.mem_read   = idex_q.mem_read;
    assign bus.mem_write  = idex_q.mem_write;
    assign bus.mem_to_reg = idex_q.mem_to_reg;
    assign bus.illegal    = idex_q.illegal;

endmodule
